// File: rtl/fwd_issue_ctrl.sv
// rtl/fwd_issue_ctrl.sv - decode-stage forwarding packet issue with load-use stall and flush bubbles
// Optional macro FWD_ISSUE_R0_ZERO_EN makes register 0 hardwired zero.
module fwd_issue_ctrl #(
  parameter int FLUSH_BUBBLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       rs0,
  input  logic [3:0]       rs1,
  input  logic [3:0]       rd,
  input  logic             uses_rs0,
  input  logic             uses_rs1,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             flush,
  output logic [13:0]      FWD_out,
  output logic             issue_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [3:0] RELOAD      = 4'(FLUSH_BUBBLES - 1);
  localparam logic       FLUSH_MULTI = (FLUSH_BUBBLES > 1);

  state_t      state, state_n;
  logic [3:0]  bub_cnt, bub_cnt_n;
  logic [13:0] pkt_n;
  logic        valid_n;
  logic        ready;
  logic        stall_inc;
  logic        flush_inc;
  logic        hz;
  logic        src0_hit;
  logic        src1_hit;
  logic        pkt_ld;
  logic        pkt_wr;

  // Hazard only against a load currently sitting in the packet register.
`ifdef FWD_ISSUE_R0_ZERO_EN
  assign src0_hit = uses_rs0 & (rs0 == FWD_out[11:8]) & (rs0 != 4'd0);
  assign src1_hit = uses_rs1 & (rs1 == FWD_out[11:8]) & (rs1 != 4'd0);
  assign pkt_wr   = reg_write & (rd != 4'd0);
  assign pkt_ld   = mem_to_reg & reg_write & (rd != 4'd0);
`else
  assign src0_hit = uses_rs0 & (rs0 == FWD_out[11:8]);
  assign src1_hit = uses_rs1 & (rs1 == FWD_out[11:8]);
  assign pkt_wr   = reg_write;
  assign pkt_ld   = mem_to_reg & reg_write;
`endif

  assign hz = FWD_out[13] & FWD_out[12] & instr_valid & (src0_hit | src1_hit);

  assign instr_ready = ready & ~rst;

  always_comb begin
    state_n   = state;
    bub_cnt_n = bub_cnt;
    pkt_n     = '0;
    valid_n   = 1'b0;
    ready     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      RUN, LSTALL: begin
        if (flush) begin
          bub_cnt_n = RELOAD;
          flush_inc = 1'b1;
          state_n   = FLUSH_MULTI ? FLUSH : RUN;
        end else if (hz) begin
          stall_inc = 1'b1;
          state_n   = LSTALL;
        end else begin
          ready   = 1'b1;
          state_n = RUN;
          if (instr_valid) begin
            pkt_n   = {pkt_ld, pkt_wr, rd, rs1, rs0};
            valid_n = 1'b1;
          end
        end
      end
      FLUSH: begin
        // Each FLUSH cycle is one bubble; the counter holds bubbles still owed.
        if (flush) begin
          bub_cnt_n = RELOAD;
          flush_inc = 1'b1;
        end else if (bub_cnt <= 4'd1) begin
          bub_cnt_n = 4'd0;
          state_n   = RUN;
        end else begin
          bub_cnt_n = bub_cnt - 4'd1;
        end
      end
      default: begin
        state_n   = RUN;
        bub_cnt_n = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      bub_cnt     <= 4'd0;
      FWD_out     <= '0;
      issue_valid <= 1'b0;
    end else begin
      state       <= state_n;
      bub_cnt     <= bub_cnt_n;
      FWD_out     <= pkt_n;
      issue_valid <= valid_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_issue_ctrl.sv
// tb/tb_fwd_issue_ctrl.sv - directed self-checking bench for fwd_issue_ctrl
module tb_fwd_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready, instr_ready_s;
  logic [3:0]  rs0 = '0, rs1 = '0, rd = '0;
  logic        uses_rs0 = 1'b0, uses_rs1 = 1'b0, reg_write = 1'b0, mem_to_reg = 1'b0;
  logic        flush = 1'b0;
  logic [13:0] fwd_out, fwd_out_s;
  logic        issue_valid, issue_valid_s;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fwd_issue_ctrl #(.FLUSH_BUBBLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs0(rs0), .rs1(rs1), .rd(rd), .uses_rs0(uses_rs0), .uses_rs1(uses_rs1),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .flush(flush),
    .FWD_out(fwd_out), .issue_valid(issue_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fwd_issue_ctrl #(.FLUSH_BUBBLES(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready_s),
    .rs0(rs0), .rs1(rs1), .rd(rd), .uses_rs0(uses_rs0), .uses_rs1(uses_rs1),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .flush(flush),
    .FWD_out(fwd_out_s), .issue_valid(issue_valid_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] d, input logic u0, input logic u1,
                           input logic rw, input logic mr);
    instr_valid = v; rs0 = s0; rs1 = s1; rd = d;
    uses_rs0 = u0; uses_rs1 = u1; reg_write = rw; mem_to_reg = mr;
    #1;
  endtask

  task automatic idle();
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_1_2_3();
    set_instr(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic load_rd5();
    set_instr(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic add_use_r5();
    set_instr(1'b1, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    flush = 1'b0;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    add_1_2_3();
    tick();
    check("rst_fwd", fwd_out, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_ready", instr_ready, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_flush", flush_cnt, 0);
    rst = 1'b0;
    #1;

    // Simple ADD issue and one-cycle packet lifetime
    check("add_ready", instr_ready, 1);
    tick();
    check("add_fwd", fwd_out, 14'h1321);
    check("add_valid", issue_valid, 1);
    idle();
    check("add_ready2", instr_ready, 1);
    tick();
    check("add_gone", fwd_out, 0);
    check("add_gone_valid", issue_valid, 0);

    // Load-use stall
    do_reset();
    load_rd5();
    tick();
    check("ld_fwd", fwd_out, 14'h3501);
    add_use_r5();
    check("hz_ready", instr_ready, 0);
    tick();
    check("hz_bubble", fwd_out, 0);
    check("hz_bubble_valid", issue_valid, 0);
    check("hz_stall_cnt", stall_cnt, 1);
    check("lstall_ready", instr_ready, 1);
    tick();
    check("hz_issue", fwd_out, 14'h1005);
    check("hz_issue_valid", issue_valid, 1);
    idle();

    // rs1 match but not used: no hazard
    do_reset();
    load_rd5();
    tick();
    set_instr(1'b1, 4'd1, 4'd5, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    check("nohz_ready", instr_ready, 1);
    tick();
    check("nohz_fwd", fwd_out, 14'h1651);
    check("nohz_stall", stall_cnt, 0);
    idle();

    // Flush pulse during RUN with instruction valid
    do_reset();
    add_1_2_3();
    flush = 1'b1;
    #1;
    check("fl_ready0", instr_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_bub1", fwd_out, 0);
    check("fl_bub1_valid", issue_valid, 0);
    check("fl_cnt", flush_cnt, 1);
    check("fl_ready1", instr_ready, 0);
    tick();
    check("fl_bub2", fwd_out, 0);
    check("fl_ready2", instr_ready, 1);
    tick();
    check("fl_resume", fwd_out, 14'h1321);
    idle();

    // Flush wins over hazard, then second flush in FLUSH reloads
    do_reset();
    load_rd5();
    tick();
    add_use_r5();
    flush = 1'b1;
    #1;
    check("fh_ready0", instr_ready, 0);
    tick();
    check("fh_flush_cnt", flush_cnt, 1);
    check("fh_stall_cnt", stall_cnt, 0);
    check("fh_ready1", instr_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fh_flush_cnt2", flush_cnt, 2);
    check("fh_ready2", instr_ready, 0);
    check("fh_bub", fwd_out, 0);
    tick();
    check("fh_ready3", instr_ready, 1);
    check("fh_bub3", fwd_out, 0);
    tick();
    check("fh_issue", fwd_out, 14'h1005);
    idle();

    // Saturation with CNT_W=2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_rd5();
      tick();
      add_use_r5();
      tick();
      idle();
      tick();
      if (i == 2) check("sat_3", stall_cnt_s, 3);
    end
    check("sat_hold", stall_cnt_s, 3);
    check("sat_wide", stall_cnt, 4);

    // Async reset mid-FLUSH
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    add_1_2_3();
    check("mid_flush_cnt", flush_cnt, 1);
    check("mid_flush_ready", instr_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_flush_cnt", flush_cnt, 0);
    check("async_ready", instr_ready, 0);
    check("async_fwd", fwd_out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", instr_ready, 1);
    tick();
    check("post_rst_fwd", fwd_out, 14'h1321);
    check("post_rst_valid", issue_valid, 1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fwd_issue_ctrl.md
Name: fwd_issue_ctrl

Overview:
- Decode-stage producer of the 14-bit forwarding packet consumed each cycle by the pipeline's forwarding unit.
- Accepts decoded instructions over a valid/ready handshake and registers one packet per cycle.
- Detects load-use hazards and inserts one bubble for each.
- Inserts flush bubbles after a taken branch.
- Keeps saturating performance counters for inserted bubbles.

Parameters:
- FLUSH_BUBBLES, 2, bubbles emitted per flush; legal range 1..15.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  instruction accepted this cycle when high with instr_valid (combinational)
- rs0  in  4  source register 0
- rs1  in  4  source register 1
- rd  in  4  destination register
- uses_rs0  in  1  instruction reads rs0
- uses_rs1  in  1  instruction reads rs1
- reg_write  in  1  instruction writes rd
- mem_to_reg  in  1  instruction is a load
- flush  in  1  taken branch/redirect from EX, single-cycle pulse or held
- FWD_out  out  14  packet {[13] MemToReg, [12] RegWrite, [11:8] rd, [7:4] rs1, [3:0] rs0}, registered
- issue_valid  out  1  FWD_out carries a real instruction (registered alongside FWD_out)
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  flush events accepted, saturating

Behaviour:
- Reset (async, immediate):
  - FWD_out = 0, issue_valid = 0, stall_cnt = 0, flush_cnt = 0.
  - State = RUN, bubble counter = 0.
  - instr_ready is low while rst is high.
- Bubble packet: all 14 bits 0; issue_valid = 0.
- Latency: instruction accepted at edge N appears on FWD_out/issue_valid after edge N, for exactly one cycle.
- If there is no accept in a cycle, the next FWD_out is a bubble. FWD_out never holds a packet across cycles.
- Load-use hazard (combinational), hz = FWD_out[13] & FWD_out[12] & instr_valid & ((uses_rs0 & rs0==FWD_out[11:8]) | (uses_rs1 & rs1==FWD_out[11:8])).
- States:
  - RUN:
    - flush=1: instr_ready=0. Next packet is a bubble. Bubble counter loads FLUSH_BUBBLES-1. flush_cnt increments. Next state is FLUSH if FLUSH_BUBBLES>1, else RUN.
    - else hz=1: instr_ready=0. Next packet is a bubble. stall_cnt increments. Next state is LSTALL.
    - else: instr_ready=1. Accept on instr_valid. Next packet = {mem_to_reg & reg_write, reg_write, rd, rs1, rs0}.
  - LSTALL:
    - Lasts exactly one cycle. FWD_out is already a bubble, so hz=0.
    - Behaves exactly as RUN for this cycle, including flush handling. The state exists for observability and for the flush-priority rule.
  - FLUSH:
    - instr_ready=0. Emit bubbles; decrement counter. Return to RUN in the cycle after the counter reads 0.
    - flush=1 while in FLUSH: reload FLUSH_BUBBLES-1, increment flush_cnt, stay in FLUSH.
- Priority: flush > hz > accept. An instruction presented in a flush cycle is dropped. The upstream refetches it.
- mem_to_reg with reg_write=0 is treated as a non-load: packet bit 13 is forced to 0.
- Counters saturate at all-ones and never wrap.
- Reset mid-flush or mid-stall: counter and state cleared; first cycle after release is RUN.

Optional Feature:
- Macro: FWD_ISSUE_R0_ZERO_EN
- Defined:
  - Register 0 is hardwired zero.
  - An accepted instruction with rd==0 issues with bits [13:12] forced to 0 (rd field still carried).
  - hz ignores source matches on register 0.
- Undefined: register 0 is an ordinary register; no special case.

Test Plan:
- Reset, then present ADD rs0=1, rs1=2, rd=3, reg_write=1 for one cycle -> next cycle FWD_out=0x1321, issue_valid=1, instr_ready=1 throughout; following cycle FWD_out=0.
- LOAD rd=5 (mem_to_reg=1, reg_write=1, rs0=1), then ADD rs0=5 held valid -> FWD_out=0x3501, then 0x0000 with instr_ready low one cycle, then 0x1005; stall_cnt=1.
- LOAD rd=5, then ADD rs1=5 with uses_rs1=0 -> no stall; ADD issues in the following cycle; stall_cnt=0.
- flush pulse during RUN with an instruction valid (FLUSH_BUBBLES=2) -> two bubble cycles with instr_ready low, instruction not issued, flush_cnt=1; accept resumes on the third cycle.
- flush asserted in the same cycle as a load-use hazard -> flush wins: flush_cnt=1, stall_cnt=0, state FLUSH. Then a second flush during FLUSH -> counter reloaded, three total bubble cycles, flush_cnt=2.
- Force stall_cnt to all-ones via repeated load-use with CNT_W=2 -> counter holds 3 after the fourth hazard. Separately: async rst asserted mid-FLUSH -> outputs zero immediately, RUN after release.
